obuffer: RTL and testbench

//  Egress buffer of the switch fabric: accepts packed 2-beat fabric words, stores them
//  in an internal FIFO and unpacks them into a 64-bit Avalon-ST beat stream
//  (valid/sop/eop/empty/error). Sits between a fabric output port and the egress client.

---
 rtl/obuffer.sv | 134 +++++++++++++
 tb/tb_obuffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/obuffer.sv
// Egress buffer: FIFO of packed 2-beat fabric words unpacked into a 64-bit Avalon-ST beat stream.
// Optional framing checker is built when OBUFFER_PKT_CHECK_EN is defined.
module obuffer #(
  parameter int PACKET_WIDTH = 142,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [PACKET_WIDTH-1:0]  i_data,
  output logic                     o_ready,
  output logic [$clog2(DEPTH):0]   o_space_left,
  output logic                     o_valid,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [2:0]               o_empty,
  output logic                     o_error,
  input  logic                     i_ready,
  output logic                     o_proto_err
);

  localparam int H  = PACKET_WIDTH / 2;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {UPPER = 1'b0, LOWER = 1'b1} phase_t;

  logic [PACKET_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [AW:0]             count_r, count_next_s;
  phase_t                  phase_r;
  logic [H-2:0]            sel_half_s;
  logic                    push_s, pop_s, load_s;

  // Handshakes, half selection and next FIFO occupancy
  always_comb begin
    push_s       = i_valid && o_ready;
    load_s       = (!o_valid || i_ready) && (count_r != {(AW+1){1'b0}});
    sel_half_s   = mem_r[rd_ptr_r][PACKET_WIDTH-2 -: H-1];
    pop_s        = 1'b0;
    count_next_s = count_r;
    if (phase_r == LOWER) begin
      sel_half_s = mem_r[rd_ptr_r][H-2:0];
      pop_s      = load_s;
    end else begin
      // A word whose lower half is invalid is consumed in a single beat
      pop_s = load_s && !mem_r[rd_ptr_r][H-1];
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers, occupancy and registered flow-control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
      o_ready      <= 1'b1;
      o_space_left <= DEPTH_C;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r      <= count_next_s;
      o_ready      <= (count_next_s < DEPTH_C);
      o_space_left <= DEPTH_C - count_next_s;
    end
  end

  // Unpack FSM and output beat register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= UPPER;
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_empty <= 3'd0;
      o_error <= 1'b0;
      o_data  <= {DATA_WIDTH{1'b0}};
    end else if (load_s) begin
      o_valid <= 1'b1;
      o_sop   <= sel_half_s[H-2];
      o_eop   <= sel_half_s[H-3];
      o_empty <= sel_half_s[H-4 -: 3];
      o_error <= sel_half_s[DATA_WIDTH];
      o_data  <= sel_half_s[DATA_WIDTH-1:0];
      case (phase_r)
        UPPER:   phase_r <= mem_r[rd_ptr_r][H-1] ? LOWER : UPPER;
        LOWER:   phase_r <= UPPER;
        default: phase_r <= UPPER;
      endcase
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef OBUFFER_PKT_CHECK_EN
  logic in_pkt_r, proto_err_r, bad_beat_s;

  // Framing violations on the beat being loaded
  always_comb begin
    bad_beat_s = (sel_half_s[H-2] && in_pkt_r) || (!sel_half_s[H-2] && !in_pkt_r) ||
                 ((phase_r == UPPER) && !mem_r[rd_ptr_r][PACKET_WIDTH-1]);
  end

  // Packet tracker and sticky protocol error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_pkt_r    <= 1'b0;
      proto_err_r <= 1'b0;
    end else if (load_s) begin
      if (bad_beat_s) proto_err_r <= 1'b1;
      in_pkt_r <= sel_half_s[H-3] ? 1'b0 : (sel_half_s[H-2] ? 1'b1 : in_pkt_r);
    end
  end

  assign o_proto_err = proto_err_r;
`else
  assign o_proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_obuffer.sv
// Scoreboard bench for obuffer: expected beats are queued on push and compared on egress handshake.
module tb_obuffer;
  localparam int PW = 142;
  localparam int DW = 64;
  localparam int D  = 16;
  localparam int H  = PW / 2;
  localparam int BW = H - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [PW-1:0] i_data = '0;
  logic          o_ready, o_valid, o_sop, o_eop, o_error, o_proto_err;
  logic [4:0]    o_space_left;
  logic [DW-1:0] o_data;
  logic [2:0]    o_empty;

  logic [BW-1:0] sb [$];
  logic [BW-1:0] mon_beat;
  int            n_chk = 0;
  int            n_pass = 0;

  obuffer dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_space_left(o_space_left), .o_valid(o_valid),
    .o_sop(o_sop), .o_eop(o_eop), .o_data(o_data), .o_empty(o_empty),
    .o_error(o_error), .i_ready(i_ready), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [H-1:0] half(input logic vld, input logic sop, input logic eop,
                                         input logic [2:0] emp, input logic err, input logic [63:0] d);
    return {vld, sop, eop, emp, err, d};
  endfunction

  // drive one word for one cycle; called at posedge+1, returns at next posedge+1
  task automatic push(input logic [PW-1:0] w, input bit accept);
    i_valid = 1'b1;
    i_data  = w;
    if (accept) begin
      sb.push_back(w[PW-2 -: BW]);
      if (w[H-1]) sb.push_back(w[BW-1:0]);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // egress monitor: a beat transfers at the posedge following a negedge with valid && ready
  always @(negedge clk) begin
    if (!reset && o_valid && i_ready) begin
      mon_beat = {o_sop, o_eop, o_empty, o_error, o_data};
      if (sb.size() == 0) check("sb_nonempty", sb.size(), 1);
      else check("beat", mon_beat, sb.pop_front());
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_space", o_space_left, 16);
    check("rst_proto", o_proto_err, 0);

    // two-beat packet and latency
    i_ready = 1'b1;
    push({half(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h11), half(1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 64'h22)}, 1'b1);
    check("lat_t0", o_valid, 0);
    @(posedge clk); #1;
    check("lat_t1", o_valid, 1);
    @(posedge clk); #1;
    check("beat2_valid", o_valid, 1);
    drain("drain_t2");

    // single-beat word followed back-to-back by a two-beat word
    push({half(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 64'hAA), {H{1'b0}}}, 1'b1);
    push({half(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h33), half(1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 64'h44)}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", o_valid, 1);
      @(posedge clk); #1;
    end
    drain("drain_t3");

    // fill with sink stalled, overflow attempt, then drain
    i_ready = 1'b0;
    for (int i = 0; i < D; i++)
      push({half(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'(2*i)), half(1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 64'(2*i+1))}, 1'b1);
    check("full_ready", o_ready, 0);
    check("full_space", o_space_left, 0);
    push({half(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 64'hDEAD), {H{1'b0}}}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", o_valid, 1);
    check("hold_data", o_data, 0);
    check("hold_sop", o_sop, 1);
    i_ready = 1'b1;
    drain("drain_t4");
    check("t4_space", o_space_left, 16);

    // reset while beats are queued
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push({half(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h100 + 64'(i)), half(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 64'h200 + 64'(i))}, 1'b1);
    check("t5_beat1", o_valid, 1);
    reset = 1'b1;
    #2;
    check("t5_valid", o_valid, 0);
    check("t5_space", o_space_left, 16);
    check("t5_ready", o_ready, 1);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    i_ready = 1'b1;
    push({half(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h77), half(1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 64'h88)}, 1'b1);
    drain("drain_t5");

    // two sop beats without an eop
    push({half(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h55), {H{1'b0}}}, 1'b1);
    push({half(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h66), {H{1'b0}}}, 1'b1);
    drain("drain_t6");
`ifdef OBUFFER_PKT_CHECK_EN
    check("proto_set", o_proto_err, 1);
    push({half(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 64'h67), {H{1'b0}}}, 1'b1);
    push({half(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 64'h68), {H{1'b0}}}, 1'b1);
    drain("drain_t6b");
    check("proto_sticky", o_proto_err, 1);
`else
    check("proto_off", o_proto_err, 0);
`endif
    reset = 1'b1;
    #2;
    check("proto_rst", o_proto_err, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
